// File: rtl/dmem_stage_pkg.sv
// Shared encodings for the data-memory pipeline stage: opcodes, func3 codes,
// FSM states and writeback exception codes.
package dmem_stage_pkg;

   localparam int CPU_WIDTH = 32;
   localparam int REG_WIDTH = 5;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
   localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10
   } state_t;

   function automatic logic writes_rd(input logic [6:0] op);
      return !(op == OP_STORE || op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/dmem_stage_lsu_align.sv
// Combinational load/store lane logic: store replication and strobes, load
// lane extraction with extension, and misalignment / illegal-func3 detection.
module lsu_align
   import dmem_stage_pkg::*;
(
   input  logic                 is_store,
   input  logic [2:0]           func3,
   input  logic [1:0]           offset,
   input  logic [CPU_WIDTH-1:0] store_data,
   input  logic [CPU_WIDTH-1:0] load_word,
   output logic [CPU_WIDTH-1:0] lane_data,
   output logic [3:0]           strobe,
   output logic [CPU_WIDTH-1:0] load_data,
   output logic                 misaligned,
   output logic                 illegal
);

   logic [7:0]  bytes [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign bytes[gi] = load_word[8*gi +: 8];
   end

   assign sel_byte = bytes[offset];
   assign sel_half = offset[1] ? load_word[31:16] : load_word[15:0];

   always_comb begin
      illegal    = is_store ? (func3 >= 3'b011)
                            : (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111);
      misaligned = 1'b0;
      if (!illegal) begin
         case (func3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset;
            default: misaligned = 1'b0;
         endcase
      end
   end

   always_comb begin
      case (func3[1:0])
         2'b00: begin
            lane_data = {4{store_data[7:0]}};
            strobe    = 4'b0001 << offset;
         end
         2'b01: begin
            lane_data = {2{store_data[15:0]}};
            strobe    = offset[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            lane_data = store_data;
            strobe    = 4'b1111;
         end
      endcase
   end

   always_comb begin
      case (func3)
         F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   load_data = {24'h0, sel_byte};
         F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
         F3_HU:   load_data = {16'h0, sel_half};
         default: load_data = load_word;
      endcase
   end

endmodule

// File: rtl/dmem_stage.sv
// Memory pipeline stage: drives a req/gnt/rvalid data bus for loads and stores,
// stalls upstream while busy, and registers the writeback bundle.
module dmem_stage
   import dmem_stage_pkg::*;
#(
   parameter int DMEM_TIMEOUT = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 M_valid_i,
   input  logic [6:0]           M_opcode_i,
   input  logic [2:0]           M_func3_i,
   input  logic [REG_WIDTH-1:0] M_rd_i,
   input  logic [CPU_WIDTH-1:0] M_valE_i,
   input  logic [CPU_WIDTH-1:0] M_valB_i,
   output logic                 m_stall_o,
   output logic                 dmem_req_o,
   output logic                 dmem_we_o,
   output logic [31:0]          dmem_addr_o,
   output logic [31:0]          dmem_wdata_o,
   output logic [3:0]           dmem_wstrb_o,
   input  logic                 dmem_gnt_i,
   input  logic                 dmem_rvalid_i,
   input  logic [31:0]          dmem_rdata_i,
   output logic                 W_valid_o,
   output logic                 W_wen_o,
   output logic [4:0]           W_rd_o,
   output logic [31:0]          W_data_o,
   output logic [1:0]           W_exc_o
);

   localparam int CNT_W = $clog2(DMEM_TIMEOUT + 1);

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg;
   logic [CPU_WIDTH-1:0] addr_reg, wdata_reg;
   logic [2:0]           func3_reg;
   logic [REG_WIDTH-1:0] rd_reg;
   logic                 is_store_reg, req_reg, we_reg;
   logic [3:0]           wstrb_reg;

   logic                 w_valid_next, w_wen_next;
   logic [REG_WIDTH-1:0] w_rd_next;
   logic [CPU_WIDTH-1:0] w_data_next;
   logic [1:0]           w_exc_next;

   logic idle, m_is_load, m_is_store, mem_op, bad, start;
   logic gnt_hit, rvalid_hit, done, abort;
   logic                 lsu_is_store, lsu_misaligned, lsu_illegal;
   logic [2:0]           lsu_func3;
   logic [1:0]           lsu_offset;
   logic [CPU_WIDTH-1:0] lsu_lane_data, lsu_load_data;
   logic [3:0]           lsu_strobe;

   assign idle       = (state_reg == ST_IDLE);
   assign m_is_load  = (M_opcode_i == OP_LOAD);
   assign m_is_store = (M_opcode_i == OP_STORE);
   assign mem_op     = M_valid_i & (m_is_load | m_is_store);

   // In IDLE the aligner judges the incoming instruction; afterwards it decodes the latched one.
   assign lsu_is_store = idle ? m_is_store    : is_store_reg;
   assign lsu_func3    = idle ? M_func3_i     : func3_reg;
   assign lsu_offset   = idle ? M_valE_i[1:0] : addr_reg[1:0];

   lsu_align u_align (
      .is_store   (lsu_is_store),
      .func3      (lsu_func3),
      .offset     (lsu_offset),
      .store_data (M_valB_i),
      .load_word  (dmem_rdata_i),
      .lane_data  (lsu_lane_data),
      .strobe     (lsu_strobe),
      .load_data  (lsu_load_data),
      .misaligned (lsu_misaligned),
      .illegal    (lsu_illegal)
   );

   assign bad        = lsu_illegal | lsu_misaligned;
   assign start      = idle & mem_op & ~bad;
   assign gnt_hit    = (state_reg == ST_REQ) & dmem_gnt_i;
   assign rvalid_hit = (state_reg == ST_WAIT) & dmem_rvalid_i;
   assign done       = (gnt_hit & is_store_reg) | rvalid_hit;
   assign abort      = ~idle & (cnt_reg >= CNT_W'(DMEM_TIMEOUT - 1)) & ~gnt_hit & ~rvalid_hit;
   assign m_stall_o  = rst_n_i & (start | (~idle & ~done & ~abort));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_REQ;
         ST_REQ: begin
            if (abort)        state_next = ST_IDLE;
            else if (gnt_hit) state_next = is_store_reg ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: if (rvalid_hit || abort) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_valid_next = 1'b0;
      w_wen_next   = 1'b0;
      w_rd_next    = '0;
      w_data_next  = '0;
      w_exc_next   = EXC_NONE;
      case (state_reg)
         ST_IDLE: begin
            if (!mem_op) begin
               w_valid_next = M_valid_i;
               w_wen_next   = M_valid_i & writes_rd(M_opcode_i) & (M_rd_i != '0);
               w_rd_next    = M_rd_i;
               w_data_next  = M_valE_i;
            end else if (bad) begin
               w_valid_next = 1'b1;
               w_rd_next    = M_rd_i;
               w_data_next  = M_valE_i;
               w_exc_next   = lsu_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
            end
         end
         ST_REQ, ST_WAIT: begin
            if (abort) begin
               w_valid_next = 1'b1;
               w_rd_next    = rd_reg;
               w_exc_next   = EXC_TIMEOUT;
            end else if (done) begin
               w_valid_next = 1'b1;
               w_rd_next    = rd_reg;
               w_wen_next   = ~is_store_reg & (rd_reg != '0);
               w_data_next  = is_store_reg ? addr_reg : lsu_load_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         req_reg      <= 1'b0;
         we_reg       <= 1'b0;
         wstrb_reg    <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         func3_reg    <= '0;
         rd_reg       <= '0;
         is_store_reg <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         if (start) begin
            req_reg      <= 1'b1;
            we_reg       <= m_is_store;
            wstrb_reg    <= m_is_store ? lsu_strobe : 4'b0000;
            addr_reg     <= M_valE_i;
            wdata_reg    <= lsu_lane_data;
            func3_reg    <= M_func3_i;
            rd_reg       <= M_rd_i;
            is_store_reg <= m_is_store;
         end else if (state_reg == ST_REQ && state_next != ST_REQ) begin
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            wstrb_reg <= '0;
         end
         if (start)      cnt_reg <= '0;
         else if (!idle) cnt_reg <= cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         W_valid_o <= 1'b0;
         W_wen_o   <= 1'b0;
         W_rd_o    <= '0;
         W_data_o  <= '0;
         W_exc_o   <= EXC_NONE;
      end else begin
         W_valid_o <= w_valid_next;
         W_wen_o   <= w_wen_next;
         W_rd_o    <= w_rd_next;
         W_data_o  <= w_data_next;
         W_exc_o   <= w_exc_next;
      end
   end

   assign dmem_req_o   = req_reg;
   assign dmem_we_o    = we_reg;
   assign dmem_wstrb_o = wstrb_reg;
   assign dmem_addr_o  = {addr_reg[31:2], 2'b00};
   assign dmem_wdata_o = wdata_reg;

endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage: expected writebacks queue up when stimulus is
// driven and are compared when the stage presents W_valid_o.
module tb_dmem_stage;
   import dmem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        M_valid, M_valid_t;
   logic [6:0]  M_opcode;
   logic [2:0]  M_func3;
   logic [4:0]  M_rd;
   logic [31:0] M_valE, M_valB;
   logic        gnt, rvalid, gnt_t, rvalid_t;
   logic [31:0] rdata;

   logic        stall, req, we, W_valid, W_wen;
   logic [31:0] addr, wdata, W_data;
   logic [3:0]  strb;
   logic [4:0]  W_rd;
   logic [1:0]  W_exc;

   logic        stall_t, req_t, we_t, W_valid_t, W_wen_t;
   logic [31:0] addr_t, wdata_t, W_data_t;
   logic [3:0]  strb_t;
   logic [4:0]  W_rd_t;
   logic [1:0]  W_exc_t;

   always #5 clk = ~clk;

   dmem_stage u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .M_valid_i(M_valid), .M_opcode_i(M_opcode),
      .M_func3_i(M_func3), .M_rd_i(M_rd), .M_valE_i(M_valE), .M_valB_i(M_valB),
      .m_stall_o(stall), .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr),
      .dmem_wdata_o(wdata), .dmem_wstrb_o(strb), .dmem_gnt_i(gnt),
      .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .W_valid_o(W_valid),
      .W_wen_o(W_wen), .W_rd_o(W_rd), .W_data_o(W_data), .W_exc_o(W_exc)
   );

   dmem_stage #(.DMEM_TIMEOUT(4)) u_to (
      .clk_i(clk), .rst_n_i(rst_n), .M_valid_i(M_valid_t), .M_opcode_i(M_opcode),
      .M_func3_i(M_func3), .M_rd_i(M_rd), .M_valE_i(M_valE), .M_valB_i(M_valB),
      .m_stall_o(stall_t), .dmem_req_o(req_t), .dmem_we_o(we_t), .dmem_addr_o(addr_t),
      .dmem_wdata_o(wdata_t), .dmem_wstrb_o(strb_t), .dmem_gnt_i(gnt_t),
      .dmem_rvalid_i(rvalid_t), .dmem_rdata_i(rdata), .W_valid_o(W_valid_t),
      .W_wen_o(W_wen_t), .W_rd_o(W_rd_t), .W_data_o(W_data_t), .W_exc_o(W_exc_t)
   );

   typedef struct {
      string       tag;
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        chk_payload;
      logic [1:0]  exc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic expect_wb(input string tag, input logic wen, input logic [4:0] rd,
                            input logic [31:0] data, input logic chk, input logic [1:0] exc);
      exp_t e;
      e.tag = tag; e.wen = wen; e.rd = rd; e.data = data; e.chk_payload = chk; e.exc = exc;
      sb.push_back(e);
   endtask

   // One clock; any writeback presented by the main instance is checked against the queue.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (W_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_wb", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            $display("WB %s wen=%0b rd=%0d data=0x%08h exc=%0d", e.tag, W_wen, W_rd, W_data, W_exc);
            check({e.tag, "_wen"}, {31'd0, W_wen}, {31'd0, e.wen});
            check({e.tag, "_exc"}, {30'd0, W_exc}, {30'd0, e.exc});
            if (e.chk_payload) begin
               check({e.tag, "_rd"}, {27'd0, W_rd}, {27'd0, e.rd});
               check({e.tag, "_data"}, W_data, e.data);
            end
         end
      end
   endtask

   task automatic drive_m(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] vale, input logic [31:0] valb);
      M_valid = v; M_opcode = op; M_func3 = f3; M_rd = rd; M_valE = vale; M_valB = valb;
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int waits,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
      drive_m(1'b1, OP_STORE, f3, 5'd0, a, d);
      #1;
      check({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
      expect_wb(tag, 1'b0, 5'd0, 32'd0, 1'b0, EXC_NONE);
      tick();
      for (int i = 0; i <= waits; i++) begin
         check({tag, "_req"}, {31'd0, req}, 32'd1);
         check({tag, "_addr"}, addr, {a[31:2], 2'b00});
         check({tag, "_wdata"}, wdata, exp_wdata);
         check({tag, "_strb"}, {28'd0, strb}, {28'd0, exp_strb});
         check({tag, "_we"}, {31'd0, we}, 32'd1);
         if (i == waits) gnt = 1'b1;
         #1;
         check({tag, "_stall_req"}, {31'd0, stall}, (i == waits) ? 32'd0 : 32'd1);
         tick();
      end
      gnt = 1'b0;
      drive_m(1'b0, OP_ALU, 3'b000, 5'd0, 32'd0, 32'd0);
      check({tag, "_req_drop"}, {31'd0, req}, 32'd0);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] rd_word, input int req_waits,
                          input int rv_waits, input logic [31:0] expv);
      drive_m(1'b1, OP_LOAD, f3, rd, a, 32'd0);
      #1;
      check({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
      expect_wb(tag, rd != 5'd0, rd, expv, 1'b1, EXC_NONE);
      tick();
      for (int i = 0; i <= req_waits; i++) begin
         check({tag, "_req"}, {31'd0, req}, 32'd1);
         check({tag, "_addr"}, addr, {a[31:2], 2'b00});
         check({tag, "_we"}, {31'd0, we}, 32'd0);
         // A stray rvalid while still requesting must be ignored.
         rvalid = (i != req_waits); rdata = 32'hBAD0_BAD0;
         if (i == req_waits) gnt = 1'b1;
         #1;
         check({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
         tick();
      end
      gnt = 1'b0; rvalid = 1'b0;
      check({tag, "_req_drop"}, {31'd0, req}, 32'd0);
      for (int i = 0; i <= rv_waits; i++) begin
         if (i == rv_waits) begin rvalid = 1'b1; rdata = rd_word; end
         #1;
         check({tag, "_stall_wait"}, {31'd0, stall}, (i == rv_waits) ? 32'd0 : 32'd1);
         tick();
      end
      rvalid = 1'b0;
      drive_m(1'b0, OP_ALU, 3'b000, 5'd0, 32'd0, 32'd0);
   endtask

   task automatic do_bad(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [1:0] exc);
      drive_m(1'b1, op, f3, 5'd9, a, 32'h0102_0304);
      #1;
      check({tag, "_stall"}, {31'd0, stall}, 32'd0);
      check({tag, "_noreq"}, {31'd0, req}, 32'd0);
      expect_wb(tag, 1'b0, 5'd9, a, 1'b0, exc);
      tick();
      check({tag, "_noreq_after"}, {31'd0, req}, 32'd0);
      drive_m(1'b0, OP_ALU, 3'b000, 5'd0, 32'd0, 32'd0);
   endtask

   logic       bub_v [4];
   logic [4:0] bub_rd [4];

   initial begin
      rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; gnt_t = 1'b0; rvalid_t = 1'b0;
      rdata = 32'd0; M_valid_t = 1'b0;
      drive_m(1'b1, OP_LOAD, F3_W, 5'd1, 32'd0, 32'd0);
      #2;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_req", {31'd0, req}, 32'd0);
      check("rst_strb", {28'd0, strb}, 32'd0);
      check("rst_wvalid", {31'd0, W_valid}, 32'd0);
      check("rst_wdata", W_data, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      drive_m(1'b0, OP_ALU, 3'b000, 5'd0, 32'd0, 32'd0);
      rst_n = 1'b1;
      tick();

      do_store("sw", F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b1111);
      tick();
      do_load("lb", F3_B, 5'd5, 32'h0000_0103, 32'h80FF_FF7F, 2, 0, 32'hFFFF_FF80);
      do_load("lbu", F3_BU, 5'd6, 32'h0000_0103, 32'h80FF_FF7F, 0, 1, 32'h0000_0080);
      do_load("lh", F3_H, 5'd7, 32'h0000_0100, 32'h80FF_FF7F, 1, 0, 32'hFFFF_FF7F);
      do_load("lhu", F3_HU, 5'd0, 32'h0000_0102, 32'h80FF_FF7F, 0, 0, 32'h0000_80FF);
      do_store("sh", F3_H, 32'h0000_0102, 32'h1234_ABCD, 1, 32'hABCD_ABCD, 4'b1100);
      do_store("sb", F3_B, 32'h0000_0101, 32'h0000_0055, 0, 32'h5555_5555, 4'b0010);
      do_bad("lh_mis", OP_LOAD, F3_H, 32'h0000_0101, EXC_MISALIGN);
      do_bad("sw_mis", OP_STORE, F3_W, 32'h0000_0102, EXC_MISALIGN);
      do_bad("ld_ill", OP_LOAD, 3'b011, 32'h0000_0100, EXC_ILLEGAL);
      do_bad("st_ill", OP_STORE, 3'b011, 32'h0000_0100, EXC_ILLEGAL);

      // Timeout: the DMEM_TIMEOUT=4 instance never sees a grant.
      M_opcode = OP_STORE; M_func3 = F3_W; M_rd = 5'd0; M_valE = 32'h200; M_valB = 32'h1;
      M_valid_t = 1'b1;
      #1;
      check("to_stall_idle", {31'd0, stall_t}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("to_req", {31'd0, req_t}, 32'd1);
         check("to_strb", {28'd0, strb_t}, 32'hF);
         check("to_stall", {31'd0, stall_t}, (i == 3) ? 32'd0 : 32'd1);
      end
      M_valid_t = 1'b0;
      tick();
      $display("WB to wvalid=%0b wen=%0b exc=%0d", W_valid_t, W_wen_t, W_exc_t);
      check("to_wvalid", {31'd0, W_valid_t}, 32'd1);
      check("to_exc", {30'd0, W_exc_t}, {30'd0, EXC_TIMEOUT});
      check("to_wen", {31'd0, W_wen_t}, 32'd0);
      check("to_req_drop", {31'd0, req_t}, 32'd0);
      rvalid_t = 1'b1;
      tick();
      rvalid_t = 1'b0;
      check("to_late_rvalid", {31'd0, W_valid_t}, 32'd0);
      check("to_idle_stall", {31'd0, stall_t}, 32'd0);

      // Reset while waiting for read data abandons the load.
      drive_m(1'b1, OP_LOAD, F3_W, 5'd7, 32'h0000_0300, 32'd0);
      tick();
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstw_req", {31'd0, req}, 32'd0);
      check("rstw_we", {31'd0, we}, 32'd0);
      check("rstw_wvalid", {31'd0, W_valid}, 32'd0);
      check("rstw_stall", {31'd0, stall}, 32'd0);
      drive_m(1'b0, OP_ALU, 3'b000, 5'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
      tick();
      rvalid = 1'b0;
      check("rstw_late_rvalid", {31'd0, W_valid}, 32'd0);

      // ALU stream with bubbles and rd=x0.
      bub_v  = '{1'b1, 1'b0, 1'b1, 1'b1};
      bub_rd = '{5'd0, 5'd3, 5'd3, 5'd0};
      for (int i = 0; i < 4; i++) begin
         drive_m(bub_v[i], OP_ALU, 3'b000, bub_rd[i], 32'h1000 + i, 32'd0);
         if (bub_v[i]) expect_wb($sformatf("alu%0d", i), bub_rd[i] != 5'd0, bub_rd[i],
                                 32'h1000 + i, 1'b1, EXC_NONE);
         #1;
         check($sformatf("alu%0d_stall", i), {31'd0, stall}, 32'd0);
         tick();
         check($sformatf("alu%0d_wvalid", i), {31'd0, W_valid}, {31'd0, bub_v[i]});
      end
      drive_m(1'b0, OP_ALU, 3'b000, 5'd0, 32'd0, 32'd0);
      tick();
      check("sb_drain", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_stage.md
DMEM_STAGE -- requirements
Module: dmem_stage

Interface
REQ-001 Parameter DMEM_TIMEOUT, default 255: bus cycles allowed in REQ+WAIT before abort.
REQ-002 clk_i  in  1  single clock, rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 M_valid_i  in  1  M register holds a real instruction (0 = bubble).
REQ-005 M_opcode_i, M_func3_i, M_rd_i  in  7/3/REG_WIDTH  from M reg.
REQ-006 M_valE_i  in  CPU_WIDTH  ALU result / effective address.
REQ-007 M_valB_i  in  CPU_WIDTH  store data (rs2).
REQ-008 m_stall_o  out  1  hold F/D/E/M registers this cycle.
REQ-009 dmem_req_o, dmem_we_o  out  1/1  bus request, write enable.
REQ-010 dmem_addr_o, dmem_wdata_o, dmem_wstrb_o  out  32/32/4  word-aligned address, lane-replicated data, byte strobes.
REQ-011 dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i  in  1/1/32  accept, read-data valid, read data.
REQ-012 W_valid_o, W_wen_o, W_rd_o, W_data_o, W_exc_o  out  1/1/5/32/2  registered writeback bundle; exc 00 none, 01 misaligned, 10 bus timeout, 11 illegal func3.

Function
REQ-013 FSM states IDLE, REQ, WAIT; mem op = valid LOAD (0000011) or STORE (0100011).
REQ-014 IDLE, non-mem or bubble: no stall; next edge W_valid_o=M_valid_i, W_data_o=M_valE_i, W_wen_o=valid & writes-rd & rd!=0.
REQ-015 IDLE, aligned legal mem op: m_stall_o=1; next state REQ, latch address/data/func3/rd.
REQ-016 Alignment: H/HU/SH need addr[0]=0; W/SW need addr[1:0]=0; violation -> no bus access, no stall, W_exc_o=01, W_wen_o=0, W_valid_o=1.
REQ-017 Load func3 011/110/111 or store func3 >=011 -> W_exc_o=11, treated as REQ-016.
REQ-018 REQ: dmem_req_o=1 (registered), held with address/data/strobes stable until dmem_gnt_i sampled high.
REQ-019 REQ+gnt, store: completion; REQ+gnt, load: next state WAIT, dmem_req_o drops next cycle.
REQ-020 WAIT: completion on dmem_rvalid_i; rvalid in REQ or IDLE ignored.
REQ-021 m_stall_o = busy & ~completion; low in completion cycle so upstream advances on the same edge FSM returns to IDLE.
REQ-022 Stalled cycles load W with W_valid_o=0 (bubble); completion edge loads the result.
REQ-023 Store: dmem_addr_o={addr[31:2],00}; SB data {4{b}}, strobe 1<<addr[1:0]; SH {2{h}}, 0011/1100; SW 1111.
REQ-024 Load: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; W_data_o=result.
REQ-025 Timeout counter clears on entry to REQ, increments each REQ/WAIT cycle; reaching DMEM_TIMEOUT: abort, W_exc_o=10, W_wen_o=0, W_valid_o=1, IDLE, no stall.
REQ-026 Minimum latency: store 2 cycles (IDLE, REQ+gnt), load 3 cycles (IDLE, REQ+gnt, WAIT+rvalid).

Reset
REQ-027 rst_n_i low: immediately state IDLE, counter 0, dmem_req_o=0, dmem_we_o=0, strobes 0, all W_* outputs 0.
REQ-028 Reset mid-transaction abandons it; no writeback, a late rvalid after release is ignored.
REQ-029 m_stall_o=0 while in reset.

Structure
REQ-030 Opcodes, func3 codes, CPU_WIDTH, REG_WIDTH, FSM state encodings, exc codes live in shared define.v.
REQ-031 Combinational sub-module lsu_align: store lane/strobe generation, load extraction/extension, misalign/illegal detect.

Verification
REQ-032 SW addr 0x100 data 0xDEADBEEF, gnt on first REQ cycle -> addr 0x100, strb 1111, stall exactly 1 cycle, W_wen_o=0.
REQ-033 LB addr 0x103, rdata 0x80FF_FF7F, gnt after 2 waits, rvalid 1 later -> W_data_o 0xFFFFFF80, rd written; LBU -> 0x00000080.
REQ-034 SH addr 0x102 data 0x1234ABCD -> wdata 0xABCDABCD, strb 1100; LH addr 0x101 -> exc 01, no dmem_req_o.
REQ-035 DMEM_TIMEOUT=4, gnt never -> abort after 4 bus cycles, exc 10, stall drops, later rvalid ignored.
REQ-036 rst_n_i low in WAIT -> req/outputs 0 same cycle; ADD rd=x0 bubble stream -> W_wen_o=0, W_valid_o follows M_valid_i.
